hazard_ctrl: RTL

Hazard and forwarding controller for the five-stage MIPS pipeline. It keeps a shadow pipeline of destination register and result-ready time (Tnew) for the E, M, W and WD stages, and from it drives the D-stage forwarding selects (ForwardRSD/ForwardRTD for the decode operand mux) and the E-stage selects. It raises `stall` on read-after-write hazards that forwarding cannot cover. It also sequences the multi-cycle mult/div unit with a busy counter, stalling HI/LO-class instructions while the unit is busy.

---
 rtl/hazard_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the five-stage MIPS pipeline: shadow pipeline
// of destination/Tnew per stage, RAW stall detection, forward selects, mult/div busy.
module hazard_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter bit          WD_FWD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic       use_rs_D,
  input  logic       use_rt_D,
  input  logic [1:0] Tuse_rs_D,
  input  logic [1:0] Tuse_rt_D,
  input  logic [4:0] dst_D,
  input  logic [1:0] Tnew_D,
  input  logic [1:0] md_D,
  output logic       stall,
  output logic [1:0] ForwardRSD,
  output logic [1:0] ForwardRTD,
  output logic [1:0] ForwardRSE,
  output logic [1:0] ForwardRTE,
  output logic       md_busy
);

  localparam int unsigned MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned CW_RAW  = $clog2(MAX_CYC + 1);
  localparam int unsigned CW      = (CW_RAW < 4) ? 4 : CW_RAW;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MULT = 2'b01,
    MD_DIV  = 2'b10,
    MD_HILO = 2'b11
  } md_e;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic [1:0] tnew;
  } ent_e_t;

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
  } ent_m_t;

  // W and WD only ever forward, so their Tnew is never consulted and is not kept.
  ent_e_t        e_q;
  ent_m_t        m_q;
  logic [4:0]    w_dst_q;
  logic [4:0]    wd_dst_q;
  logic [CW-1:0] cnt_q, cnt_d;

  md_e  md;
  logic stall_rs, stall_rt, stall_md;

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'b00) ? 2'b00 : t - 2'b01;
  endfunction

  // The youngest in-flight writer of the register decides; older ones are shadowed.
  function automatic logic raw_stall(input logic use_r, input logic [4:0] r,
                                     input logic [1:0] tuse, input ent_e_t e,
                                     input ent_m_t m);
    if (!use_r || r == 5'd0) return 1'b0;
    if (e.dst == r)          return e.tnew > tuse;
    if (m.dst == r)          return m.tnew > tuse;
    return 1'b0;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic [4:0] dm,
                                         input logic [1:0] tm, input logic [4:0] dw,
                                         input logic [4:0] dwd, input logic use_wd);
    if (r == 5'd0)           return 2'b00;
    if (dm == r)             return (tm == 2'b00) ? 2'b01 : 2'b00;
    if (dw == r)             return 2'b10;
    if (use_wd && dwd == r)  return 2'b11;
    return 2'b00;
  endfunction

  assign md       = md_e'(md_D);
  assign md_busy  = (cnt_q != '0);
  assign stall_rs = raw_stall(use_rs_D, rs_D, Tuse_rs_D, e_q, m_q);
  assign stall_rt = raw_stall(use_rt_D, rt_D, Tuse_rt_D, e_q, m_q);
  assign stall_md = (md != MD_NONE) && md_busy;
  assign stall    = stall_rs | stall_rt | stall_md;

  assign ForwardRSD = fwd_sel(rs_D, m_q.dst, m_q.tnew, w_dst_q, wd_dst_q, WD_FWD);
  assign ForwardRTD = fwd_sel(rt_D, m_q.dst, m_q.tnew, w_dst_q, wd_dst_q, WD_FWD);
  assign ForwardRSE = fwd_sel(e_q.rs, m_q.dst, m_q.tnew, w_dst_q, wd_dst_q, 1'b0);
  assign ForwardRTE = fwd_sel(e_q.rt, m_q.dst, m_q.tnew, w_dst_q, wd_dst_q, 1'b0);

  always_comb begin
    cnt_d = cnt_q;
    if (!stall && md == MD_MULT)     cnt_d = CW'(MULT_CYC);
    else if (!stall && md == MD_DIV) cnt_d = CW'(DIV_CYC);
    else if (cnt_q != '0)            cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q      <= '0;
      m_q      <= '0;
      w_dst_q  <= '0;
      wd_dst_q <= '0;
      cnt_q    <= '0;
    end else begin
      e_q      <= stall ? '0 : {rs_D, rt_D, dst_D, Tnew_D};
      m_q      <= '{dst: e_q.dst, tnew: dec_sat(e_q.tnew)};
      w_dst_q  <= m_q.dst;
      wd_dst_q <= w_dst_q;
      cnt_q    <= cnt_d;
    end
  end

endmodule
